// File: rtl/control_sequencer_pkg.sv
// Shared definitions for control_sequencer: state encoding, opcodes, IR field positions
// and the opcode-class helpers used by T4 dispatch and T6 writeback.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
    } state_e;

    localparam int FIELD_W = 4;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_binary(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_MUL, OP_DIV: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/control_sequencer_reg_field_decoder.sv
// reg_field_decoder: turns a 4-bit register field plus enable into a one-hot select.
module reg_field_decoder
    import control_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [FIELD_W-1:0]  field_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // Fields beyond the register file decode to no select at all.
    always_comb begin
        onehot_o = '0;
        if (en_i && (int'(field_i) < NUM_REGS)) begin
            onehot_o[field_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute strobe sequencer for the single-bus datapath.
// Defining MEM_TIMEOUT_EN adds a bounded T2 wait and a sticky fault output.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         IR,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                MARin,
    output logic                PCin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                read,
    output logic [4:0]          alu_op,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                run,
    output logic                illegal
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                fault
`endif
);

    state_e             state_q, state_d;
    logic [4:0]         opcode;
    logic [FIELD_W-1:0] ra, rb, rc, rout_field;
    logic               rin_en, rout_en, rout_sel_rc;
    logic               unused_bits;

    assign opcode      = IR[OPC_MSB:OPC_LSB];
    assign ra          = IR[RA_MSB:RA_LSB];
    assign rb          = IR[RB_MSB:RB_LSB];
    assign rc          = IR[RC_MSB:RC_LSB];
    assign rout_field  = rout_sel_rc ? rc : rb;
    assign unused_bits = ^{IR[RC_LSB-1:0], (MEM_TIMEOUT != 0)};

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`endif

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_RST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        PCout       = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        MDRout      = 1'b0;
        MARin       = 1'b0;
        PCin        = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        HIin        = 1'b0;
        LOin        = 1'b0;
        IncPC       = 1'b0;
        read        = 1'b0;
        alu_op      = 5'b00000;
        illegal     = 1'b0;
        rin_en      = 1'b0;
        rout_en     = 1'b0;
        rout_sel_rc = 1'b0;
        run         = (state_q != S_RST) && (state_q != S_HALTED);
`ifdef MEM_TIMEOUT_EN
        wait_d      = wait_q;
        fault_d     = fault_q;
`endif
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                read    = 1'b1;
                state_d = S_T2;
`ifdef MEM_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_T2: begin
                read = 1'b1;
                if (mem_ready) begin
                    MDRin   = 1'b1;
                    state_d = S_T3;
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    wait_d = wait_q + CNT_W'(1);
                    if (wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = S_HALTED;
                        fault_d = 1'b1;
                    end
                end
`endif
            end
            S_T3: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T4;
            end
            S_T4: begin
                if (is_binary(opcode)) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                    state_d = S_T5;
                end else if (is_unary(opcode)) begin
                    rout_en = 1'b1;
                    Zin     = 1'b1;
                    alu_op  = opcode;
                    state_d = S_T6;
                end else if (opcode == OP_NOP) begin
                    state_d = S_T0;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    illegal = 1'b1;
                    state_d = S_T0;
                end
            end
            S_T5: begin
                rout_en     = 1'b1;
                rout_sel_rc = 1'b1;
                Zin         = 1'b1;
                alu_op      = opcode;
                state_d     = S_T6;
            end
            S_T6: begin
                Zlowout = 1'b1;
                if (is_muldiv(opcode)) begin
                    LOin    = 1'b1;
                    state_d = S_T7;
                end else begin
                    rin_en  = 1'b1;
                    state_d = S_T0;
                end
            end
            S_T7: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = S_T0;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RST;
        endcase
    end

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
        .field_i  (ra),
        .en_i     (rin_en),
        .onehot_o (Rin)
    );

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
        .field_i  (rout_field),
        .en_i     (rout_en),
        .onehot_o (Rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction strobe sequences built from opcode classes,
// compared every cycle, plus literal pins on directed instructions.
module tb_control_sequencer;

    localparam logic [4:0] O_ADD = 5'b00011, O_SUB = 5'b00100, O_SHR = 5'b00101,
                           O_SHL = 5'b00110, O_ROR = 5'b00111, O_ROL = 5'b01000,
                           O_AND = 5'b01001, O_OR  = 5'b01010, O_MUL = 5'b01110,
                           O_DIV = 5'b01111, O_NEG = 5'b10000, O_NOT = 5'b10001,
                           O_NOP = 5'b11010, O_HLT = 5'b11011;
    localparam int C_NOP = 0, C_UN = 1, C_BIN = 2, C_MD = 3, C_HALT = 4, C_ILL = 5;

    typedef struct packed {
        logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
        logic Yin, Zin, HIin, LOin, IncPC, read, run, illegal, fault;
        logic [4:0]  alu_op;
        logic [15:0] Rin;
        logic [15:0] Rout;
    } obs_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] IR = 32'd0;
    logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
    logic Yin, Zin, HIin, LOin, IncPC, read, run, illegal;
    logic [4:0]  alu_op;
    logic [15:0] Rin, Rout;
`ifdef MEM_TIMEOUT_EN
    logic fault;
`endif

    control_sequencer #(.NUM_REGS(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .read(read), .alu_op(alu_op),
        .Rin(Rin), .Rout(Rout), .run(run), .illegal(illegal)
`ifdef MEM_TIMEOUT_EN
        , .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    exp_valid = 1'b0;
    obs_t  exp_cur;
    string cur_tag = "";
    obs_t  snap[$];
    string       lit_name[$];
    logic [31:0] lit_act[$];
    logic [31:0] lit_req[$];

    function automatic obs_t dut_obs();
        obs_t o;
        o = '0;
        o.PCout = PCout;   o.Zlowout = Zlowout; o.Zhighout = Zhighout; o.MDRout = MDRout;
        o.MARin = MARin;   o.PCin = PCin;       o.MDRin = MDRin;       o.IRin = IRin;
        o.Yin = Yin;       o.Zin = Zin;         o.HIin = HIin;         o.LOin = LOin;
        o.IncPC = IncPC;   o.read = read;       o.run = run;           o.illegal = illegal;
        o.alu_op = alu_op; o.Rin = Rin;         o.Rout = Rout;
`ifdef MEM_TIMEOUT_EN
        o.fault = fault;
`endif
        return o;
    endfunction

    // Single checking process: per-cycle model compare plus queued literal pins.
    initial begin
        obs_t  act;
        string nm;
        logic [31:0] a, r;
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                act = dut_obs();
                n_tests = n_tests + 1;
                if (act !== exp_cur) begin
                    n_fail = n_fail + 1;
                    $display("FAIL cycle %0d %s: got %h required %h", cyc, cur_tag, act, exp_cur);
                end
            end
            while (lit_name.size() > 0) begin
                nm = lit_name.pop_front();
                a  = lit_act.pop_front();
                r  = lit_req.pop_front();
                n_tests = n_tests + 1;
                if (a !== r) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got %0h required %0h", nm, a, r);
                end
            end
        end
    end

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] r);
        lit_name.push_back(n);
        lit_act.push_back(a);
        lit_req.push_back(r);
    endtask

    task automatic step(input obs_t e, input logic mr, input logic [31:0] ir,
                        input logic c, input string tag);
        @(posedge clk);
        #1;
        mem_ready = mr;
        IR        = ir;
        clr       = c;
        exp_cur   = e;
        cur_tag   = tag;
        exp_valid = 1'b1;
        cyc       = cyc + 1;
        #1;
        snap.push_back(dut_obs());
    endtask

    function automatic obs_t active();
        obs_t o;
        o = '0;
        o.run = 1'b1;
        return o;
    endfunction

    function automatic int op_class(input logic [4:0] op);
        case (op)
            O_ADD, O_SUB, O_SHR, O_SHL, O_ROR, O_ROL, O_AND, O_OR: return C_BIN;
            O_MUL, O_DIV: return C_MD;
            O_NEG, O_NOT: return C_UN;
            O_NOP:        return C_NOP;
            O_HLT:        return C_HALT;
            default:      return C_ILL;
        endcase
    endfunction

    // One instruction: fetch with w wait cycles (optionally aborted by clr), then execute.
    task automatic run_instr(input logic [31:0] ir, input int w, input int abort_at,
                             output int ncyc);
        obs_t e;
        int   cls;
        logic [4:0] op;
        op  = ir[31:27];
        cls = op_class(op);
        snap.delete();
        e = active(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
        step(e, 1'($urandom), $urandom, 1'b0, "T0");
        e = active(); e.Zlowout = 1; e.PCin = 1; e.read = 1;
        step(e, 1'($urandom), $urandom, 1'b0, "T1");
        for (int k = 0; k <= w; k++) begin
            e = active(); e.read = 1;
            if (k == abort_at) begin
                step(e, 1'b0, $urandom, 1'b1, "T2clr");
                step('0, 1'($urandom), $urandom, 1'b0, "RST");
                ncyc = snap.size();
                return;
            end
            e.MDRin = (k == w);
            step(e, (k == w), $urandom, 1'b0, "T2");
        end
        e = active(); e.MDRout = 1; e.IRin = 1;
        step(e, 1'($urandom), $urandom, 1'b0, "T3");
        e = active();
        if (cls == C_BIN || cls == C_MD) begin
            e.Rout = 16'(1) << ir[22:19]; e.Yin = 1;
            step(e, 1'($urandom), ir, 1'b0, "T4");
            e = active(); e.Rout = 16'(1) << ir[18:15]; e.Zin = 1; e.alu_op = op;
            step(e, 1'($urandom), ir, 1'b0, "T5");
        end else if (cls == C_UN) begin
            e.Rout = 16'(1) << ir[22:19]; e.Zin = 1; e.alu_op = op;
            step(e, 1'($urandom), ir, 1'b0, "T4");
        end else begin
            e.illegal = (cls == C_ILL);
            step(e, 1'($urandom), ir, 1'b0, "T4");
        end
        if (cls == C_BIN || cls == C_UN || cls == C_MD) begin
            e = active(); e.Zlowout = 1;
            if (cls == C_MD) e.LOin = 1;
            else             e.Rin  = 16'(1) << ir[26:23];
            step(e, 1'($urandom), ir, 1'b0, "T6");
            if (cls == C_MD) begin
                e = active(); e.Zhighout = 1; e.HIin = 1;
                step(e, 1'($urandom), ir, 1'b0, "T7");
            end
        end
        ncyc = snap.size();
    endtask

    task automatic halt_hold_then_reset(input int n);
        for (int i = 0; i < n; i++) step('0, 1'($urandom), $urandom, 1'b0, "HALTED");
        step('0, 1'($urandom), $urandom, 1'b1, "HCLR");
        step('0, 1'($urandom), $urandom, 1'b0, "RST");
    endtask

    initial begin
        int          nc;
        int          w;
        int          ab;
        logic [4:0]  op;
        logic [31:0] ir;
        logic [4:0]  ops [14];
        ops = '{O_ADD, O_SUB, O_SHR, O_SHL, O_ROR, O_ROL, O_AND, O_OR,
                O_MUL, O_DIV, O_NEG, O_NOT, O_NOP, O_HLT};

        snap.delete();
        repeat (3) step('0, 1'($urandom), $urandom, 1'b1, "CLR");
        step('0, 1'($urandom), $urandom, 1'b0, "RST");
        lit("rst_run", 32'(snap[2].run), 32'd0);

        run_instr(32'h4A920000, 0, -1, nc);
        lit("t0_pcout", 32'(snap[0].PCout), 32'd1);
        lit("t0_run", 32'(snap[0].run), 32'd1);
        lit("and_len", nc, 32'd7);
        lit("and_t4_rout", 32'(snap[4].Rout), 32'h0004);
        lit("and_t4_yin", 32'(snap[4].Yin), 32'd1);
        lit("and_t5_rout", 32'(snap[5].Rout), 32'h0010);
        lit("and_t5_aluop", 32'(snap[5].alu_op), 32'b01001);
        lit("and_t6_rin", 32'(snap[6].Rin), 32'h0020);

        run_instr(32'h701A0000, 0, -1, nc);
        lit("mul_len", nc, 32'd8);
        lit("mul_t6_lo", 32'(snap[6].LOin), 32'd1);
        lit("mul_t6_rin", 32'(snap[6].Rin), 32'd0);
        lit("mul_t7_hi", 32'(snap[7].HIin), 32'd1);

        run_instr(32'h88B00000, 0, -1, nc);
        lit("not_len", nc, 32'd6);
        lit("not_t4_rout", 32'(snap[4].Rout), 32'h0040);
        lit("not_t4_aluop", 32'(snap[4].alu_op), 32'b10001);
        lit("not_t4_yin", 32'(snap[4].Yin), 32'd0);
        lit("not_t6_rin", 32'(snap[5].Rin), 32'h0002);

        run_instr(32'hD0000000, 0, -1, nc);
        lit("nop_len", nc, 32'd5);

        ir = {O_ADD, 4'd7, 4'd8, 4'd9, 15'h1234};
        run_instr(ir, 4, -1, nc);
        lit("add_wait_len", nc, 32'd11);
        lit("add_w4_mdrin", 32'(snap[5].MDRin), 32'd0);
        lit("add_w5_mdrin", 32'(snap[6].MDRin), 32'd1);
        run_instr(ir, 4, 1, nc);
        lit("abort_len", nc, 32'd5);
        lit("abort_rst_run", 32'(snap[4].run), 32'd0);

        run_instr(32'hF8000000, 0, -1, nc);
        lit("ill_t4", 32'(snap[4].illegal), 32'd1);
        lit("ill_len", nc, 32'd5);

        run_instr(32'hD8000000, 0, -1, nc);
        lit("halt_len", nc, 32'd5);
        halt_hold_then_reset(20);

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
            ir = {op, 27'($urandom)};
            w  = $urandom_range(0, 3);
            ab = (w > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, w - 1) : -1;
            run_instr(ir, w, ab, nc);
            if (ab < 0 && op_class(op) == C_HALT) halt_hold_then_reset($urandom_range(1, 5));
        end

`ifdef MEM_TIMEOUT_EN
        begin
            obs_t e;
            e = active(); e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zin = 1;
            step(e, 1'b0, $urandom, 1'b0, "TO_T0");
            e = active(); e.Zlowout = 1; e.PCin = 1; e.read = 1;
            step(e, 1'b0, $urandom, 1'b0, "TO_T1");
            e = active(); e.read = 1;
            repeat (15) step(e, 1'b0, $urandom, 1'b0, "TO_T2");
            e = '0; e.fault = 1;
            repeat (4) step(e, 1'b0, $urandom, 1'b0, "TO_HALT");
            step(e, 1'b0, $urandom, 1'b1, "TO_CLR");
            step('0, 1'b0, $urandom, 1'b0, "TO_RST");
        end
`endif

        run_instr(32'hD0000000, 0, -1, nc);
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Multi-cycle control unit for the 32-bit single-bus datapath. Each cycle it emits the bus-drive (`*out`), register-load (`*in`), memory and ALU-op strobes that sequence three phases:
- instruction fetch (PC→MAR, PC+1, memory read into MDR, MDR→IR);
- decode of the IR fields returned from the datapath;
- execute and writeback for register ALU, MUL/DIV, NOP and HALT instructions.

The memory read is handshaked with `mem_ready`.

Parameters:
- NUM_REGS, 16, general-purpose registers; width of the one-hot Rin/Rout vectors.
- MEM_TIMEOUT, 15, maximum wait cycles in T2 (used only with `MEM_TIMEOUT_EN`).

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous active-high reset
- IR  in  32  IR_Data_Out from datapath; opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
- mem_ready  in  1  memory data valid on Mdatain this cycle
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus-drive selects
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load enables
- IncPC  out  1  ALU computes bus+1
- read  out  1  MDR selects Mdatain; memory read request
- alu_op  out  5  ALU opcode
- Rin  out  NUM_REGS  one-hot GPR load
- Rout  out  NUM_REGS  one-hot GPR bus drive
- run  out  1  high unless in RST or HALTED
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED. State is registered; outputs are decoded combinationally from the state and IR. Loads take effect at the clock edge that ends the state.
- clr=1 → next state RST regardless of current state, including mid-fetch and HALTED. In RST every output is 0, including run. RST→T0 on the first cycle with clr=0.
- Any output not listed for a state is 0.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, read. Next state T2.
- T2: read held. If mem_ready=1: MDRin=1, next state T3. Otherwise stay in T2 with MDRin=0.
- T3: MDRout, IRin. Next state T4. IR fields are valid from T4 onward.
- Opcodes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001, NOP 11010, HALT 11011.
- T4 dispatch on opcode:
  - Binary (ADD–OR, MUL, DIV): Rout[Rb], Yin. Next state T5.
  - Unary (NEG, NOT): Rout[Rb], Zin, alu_op=opcode. Next state T6.
  - NOP: all outputs 0. Next state T0.
  - HALT: all outputs 0. Next state HALTED.
  - Any other opcode: illegal=1 for this cycle, treated as NOP. Next state T0.
- T5: Rout[Rc], Zin, alu_op=opcode. Next state T6.
- T6:
  - MUL/DIV: Zlowout, LOin. Next state T7.
  - Otherwise: Zlowout, Rin[Ra]. Next state T0.
- T7: Zhighout, HIin. Next state T0.
- HALTED: run=0, all strobes 0. Leaves only via clr.
- alu_op=00000 in every state except T4 (unary) and T5.
- Rin and Rout are at most one-hot. Ra=0 is a legal destination; there is no R0 special case.
- Latency with mem_ready high in its first T2 cycle:
  - NOP: 5 cycles.
  - Unary: 6 cycles.
  - Binary: 7 cycles.
  - MUL/DIV: 8 cycles.
  - Each T2 wait cycle adds 1.
- mem_ready outside T2 is ignored.

Optional Feature:
`MEM_TIMEOUT_EN`
- Defined:
  - Adds output `fault` (1 bit) and an internal wait counter.
  - The counter clears on entry to T2 and increments on each T2 cycle with mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is HALTED and `fault` becomes 1.
  - `fault` stays 1 until clr.
- Undefined: no `fault` port and no counter; T2 waits indefinitely.

Decomposition:
- Shared package: opcode constants, state encoding, IR field bit positions.
- One sub-module, reg_field_decoder: 4-bit field plus enable in, NUM_REGS one-hot out. Instantiated once for Rin (field Ra) and once for Rout (field Rb or Rc, muxed by state).

Test Plan:
- clr held 3 cycles, then released → all outputs 0 during clr. T0 (PCout, MARin, IncPC, Zin) appears on the first cycle after release; run=1.
- IR=0x4A920000 (AND R5,R2,R4), mem_ready=1 → 7 cycles:
  - T4: Rout=0x0004, Yin.
  - T5: Rout=0x0010, alu_op=01001, Zin.
  - T6: Zlowout, Rin=0x0020.
  - Next cycle is T0.
- IR=0x701A0000 (MUL R3,R4) → T6: Zlowout, LOin. T7: Zhighout, HIin. Rin=0 throughout. Total 8 cycles.
- IR=0x88B00000 (NOT R1,R6) → T4: Rout=0x0040, Zin, alu_op=10001; no Yin. T6: Rin=0x0002. T5 never entered.
- mem_ready low for 4 T2 cycles during ADD fetch → read stays high; MDRin only in the 5th T2 cycle; ADD completes in 11 cycles. Repeat with clr asserted in the 2nd T2 cycle → RST next cycle, then T0.
- IR=0xD8000000 (HALT) → HALTED after T4, run=0, strobes 0 for 20 cycles. Opcode 11111 → illegal pulse in T4, then T0.
- With `MEM_TIMEOUT_EN`: mem_ready stuck low → fault=1 and HALTED after 15 wait cycles.
